// File: rtl/div_iter.sv
// Radix-2 restoring divider for the EX stage: one quotient bit per clock, with
// divide-by-zero short cut, flush annulment and a stall request while busy.
module div_iter #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 annul_i,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic [1:0]           state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, DZERO = 2'd1, CALC = 2'd2, DONE = 2'd3} state_t;

  state_t             state, state_nx;
  logic [CW-1:0]      cnt, cnt_nx;
  logic [WIDTH-1:0]   rem, rem_nx;
  logic [WIDTH-1:0]   dvd, dvd_nx;
  logic [WIDTH-1:0]   dsr, dsr_nx;
  logic               sign_q, sign_q_nx;
  logic               sign_r, sign_r_nx;
  logic [2*WIDTH-1:0] result_nx;
  logic               ready_nx;

  logic               s1, s2;
  logic [WIDTH-1:0]   abs1, abs2;
  logic [WIDTH-1:0]   rem_sh, trial, rem_it;
  logic               q_bit;

  assign s1   = SIGNED_EN && signed_div_i && opdata1_i[WIDTH-1];
  assign s2   = SIGNED_EN && signed_div_i && opdata2_i[WIDTH-1];
  assign abs1 = s1 ? -opdata1_i : opdata1_i;
  assign abs2 = s2 ? -opdata2_i : opdata2_i;

  // The shifted-out remainder MSB stands in for bit WIDTH of the WIDTH+1 bit
  // trial subtract: when it is set the shifted value already exceeds the divisor,
  // and the true difference is below the divisor, so the low WIDTH bits are exact.
  assign rem_sh = {rem[WIDTH-2:0], dvd[WIDTH-1]};
  assign q_bit  = rem[WIDTH-1] | (rem_sh >= dsr);
  assign trial  = rem_sh - dsr;
  assign rem_it = q_bit ? trial : rem_sh;

  // Handshake: ready_o is the valid flag for result_o; it stays up while
  // start_i is held, and dropping start_i acts as the consumer's acknowledge.
  assign busy_o    = (state == CALC) || (state == DZERO);
  assign state_dbg = state;

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    rem_nx    = rem;
    dvd_nx    = dvd;
    dsr_nx    = dsr;
    sign_q_nx = sign_q;
    sign_r_nx = sign_r;
    result_nx = result_o;
    ready_nx  = ready_o;
    case (state)
      IDLE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i != '0) begin
            state_nx  = CALC;
            cnt_nx    = '0;
            rem_nx    = '0;
            dvd_nx    = abs1;
            dsr_nx    = abs2;
            sign_q_nx = s1 ^ s2;
            sign_r_nx = s1;
          end else begin
            state_nx = DZERO;
          end
        end
      end
      DZERO: begin
        if (annul_i) begin
          state_nx  = IDLE;
          ready_nx  = 1'b0;
          result_nx = '0;
        end else begin
          state_nx  = DONE;
          ready_nx  = 1'b1;
          result_nx = '0;
        end
      end
      CALC: begin
        if (annul_i) begin
          state_nx  = IDLE;
          ready_nx  = 1'b0;
          result_nx = '0;
        end else if (cnt == CW'(WIDTH)) begin
          state_nx  = DONE;
          ready_nx  = 1'b1;
          result_nx = {(sign_r ? -rem : rem), (sign_q ? -dvd : dvd)};
        end else begin
          rem_nx = rem_it;
          dvd_nx = {dvd[WIDTH-2:0], q_bit};
          cnt_nx = cnt + 1'b1;
        end
      end
      DONE: begin
        if (annul_i || !start_i) begin
          state_nx  = IDLE;
          ready_nx  = 1'b0;
          result_nx = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      dvd      <= '0;
      dsr      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      rem      <= rem_nx;
      dvd      <= dvd_nx;
      dsr      <= dsr_nx;
      sign_q   <= sign_q_nx;
      sign_r   <= sign_r_nx;
      result_o <= result_nx;
      ready_o  <= ready_nx;
    end
  end

endmodule
